lives_counter_param: RTL
========================

// Module: lives_counter_param
// PURPOSE
//   Parametrised up/down counter with load, saturate/wrap mode and post-decrement
//   hold-off. Next generation of the game's lives counter: tracks player lives,
//   enforces an invulnerability window after each hit, and flags 0/max to the
//   game FSM. Also reused as a generic bounded counter (shields, ammo).
// PARAMETERS
//   WIDTH     4  counter width in bits
//   INIT_VAL  3  value of Q after clr
//   MAX_VAL   9  upper bound of Q; must be <= 2**WIDTH-1 and >= INIT_VAL
//   WRAP      0  0 = saturate at 0/MAX_VAL; 1 = wrap 0<->MAX_VAL
//   HOLDOFF   4  cycles decrements are ignored after an accepted decrement; 0 = none
// PORTS
//   clock  in   1      rising-edge clock
//   clr    in   1      asynchronous, active-high reset
//   ld     in   1      synchronous load of D
//   D      in   WIDTH  load value
//   ent    in   1      count enable (also gates rco)
//   enp    in   1      count enable
//   up     in   1      direction: 1 = increment, 0 = decrement
//   Q      out  WIDTH  count value (registered)
//   rco    out  1      terminal count in current direction (combinational)
//   zero   out  1      Q == 0 (combinational)
//   busy   out  1      hold-off active (registered)
//   ovf    out  1      one-cycle pulse: increment requested at MAX_VAL
//   unf    out  1      one-cycle pulse: accepted decrement requested at 0
// BEHAVIOUR
//   - clr is asynchronous, active-high; it overrides everything.
//     While clr is high: Q=INIT_VAL, hold-off count=0, busy=0, ovf=0, unf=0.
//   - Priority at each rising edge: clr > ld > count > hold.
//   - Load: ld=1 -> Q <= min(D, MAX_VAL). Any count request that cycle is discarded.
//     ld does not change the hold-off count.
//   - Count request = ent & enp & ~ld.
//   - Up request:
//       Q < MAX_VAL -> Q+1.
//       Q == MAX_VAL -> Q stays (WRAP=0) or becomes 0 (WRAP=1); ovf=1 next cycle.
//   - Down request while busy=1: ignored. Q unchanged, no pulse, hold-off not restarted.
//   - Down request while busy=0:
//       Q > 0 -> Q-1, accepted.
//       Q == 0, WRAP=0 -> Q stays 0; unf=1; not accepted (no hold-off).
//       Q == 0, WRAP=1 -> Q=MAX_VAL, accepted; unf=1.
//   - Hold-off counter: width $clog2(HOLDOFF+1).
//       Accepted decrement at edge t loads HOLDOFF.
//       Otherwise the counter decrements toward 0, 1 per cycle.
//       busy = (count != 0): high for HOLDOFF cycles after edge t; next decrement
//       is accepted at edge t+HOLDOFF+1. Increments are never blocked by busy.
//       HOLDOFF=0: busy is constant 0.
//   - rco = ent & (up ? Q==MAX_VAL : Q==0); independent of enp, busy and ld.
//   - ovf and unf: registered, high exactly one cycle per event, 0 otherwise.
//     Back-to-back saturated requests give a pulse every cycle.
//   - No arithmetic may overflow WIDTH: all comparisons are against MAX_VAL/0
//     before the step is applied.
//   - clr mid hold-off or mid pulse: all state returns to reset values immediately.
// TESTING  (defaults unless stated)
//   1. clr pulse, then release -> Q=3, busy=0, zero=0.
//      ld=1, D=12 -> Q=9. Then D=5 -> Q=5.
//   2. Q=1, single down request -> Q=0, busy=1 for 4 cycles.
//      Down requests held continuously -> no further effect; zero=1 and rco=1 (ent=1).
//      After busy falls, one more down request -> Q stays 0, unf pulses 1 cycle.
//   3. Q=3, down held every cycle -> Q goes 3->2 at t, 2->1 at t+5, 1->0 at t+10;
//      busy low only at the request edges.
//   4. WRAP=1: Q=0, down request -> Q=9, unf pulse.
//      Q=9, up request -> Q=0, ovf pulse.
//      WRAP=0: up at Q=9 held 3 cycles -> Q=9, ovf high 3 cycles.
//   5. ld=1 with ent=enp=1, up=1, D=2 -> Q=2, no increment.
//      ent=1, enp=0 -> Q unchanged, rco still follows Q.
//   6. clr asserted mid-cycle during busy with ovf pending -> Q=3, busy=0,
//      ovf=0, unf=0 before the next clock edge.
//      HOLDOFF=0 build: consecutive decrements every cycle.

Source files
------------

// File: rtl/lives_counter_param.sv
// Bounded up/down counter with load, saturate/wrap and a post-decrement hold-off
// window; used for player lives and other capped resources (shields, ammo).
module lives_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_VAL = 3,
  parameter int unsigned MAX_VAL  = 9,
  parameter bit          WRAP     = 1'b0,
  parameter int unsigned HOLDOFF  = 4
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  input  logic             ent,
  input  logic             enp,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             zero,
  output logic             busy,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT_VAL);
  localparam logic [HW-1:0]    HOLD_Q = HW'(HOLDOFF);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             cnt_req;
  logic             busy_w;

  assign cnt_req = ent & enp & ~ld;
  assign busy_w  = (hold_q != '0);

  // Next-state: load beats counting; every bound check happens before the step.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = busy_w ? hold_q - HW'(1) : '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (ld) begin
      cnt_d = (D > MAX_Q) ? MAX_Q : D;
    end else if (cnt_req) begin
      if (up) begin
        if (cnt_q == MAX_Q) begin
          ovf_d = 1'b1;
          if (WRAP) cnt_d = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else if (!busy_w) begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - WIDTH'(1);
          hold_d = HOLD_Q;
        end else begin
          unf_d = 1'b1;
          if (WRAP) begin
            cnt_d  = MAX_Q;
            hold_d = HOLD_Q;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      cnt_q  <= INIT_Q;
      hold_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign Q    = cnt_q;
  assign busy = busy_w;
  assign ovf  = ovf_q;
  assign unf  = unf_q;
  assign zero = (cnt_q == '0);
  assign rco  = ent & (up ? (cnt_q == MAX_Q) : (cnt_q == '0));

endmodule
